// File: rtl/mmio_word_ports.sv
// Memory-mapped bank of NUM_IN input and NUM_OUT output word channels.
// Define INPUT_SYNC_EN to add a 2-flop synchroniser ahead of input capture.
module mmio_word_ports #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                NUM_IN    = 2,
    parameter int                NUM_OUT   = 2,
    parameter logic [DATA_W-1:0] OUT_RESET = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_be,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,
    input  logic [NUM_IN*DATA_W-1:0]  in_words,
    output logic [NUM_OUT*DATA_W-1:0] out_words
);
    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0]        inCap [NUM_IN];
    logic [DATA_W-1:0]        inPrev [NUM_IN];
    logic [DATA_W-1:0]        outReg [NUM_OUT];
    logic [NUM_IN-1:0]        flags;
    logic [NUM_IN-1:0]        changeNow;
    logic [NUM_IN*DATA_W-1:0] capSrc;

    logic              respValid;
    logic [DATA_W-1:0] respRdata;
    logic              respErr;

    logic [3:0]        idx;
    logic              aligned, inRange;
    logic              isIn, isOut, isStat;
    logic              inHit, outHit, okAcc;
    logic              accept, statRead;
    logic [DATA_W-1:0] inData, outData, statWord, rdVal;

`ifdef INPUT_SYNC_EN
    logic [NUM_IN*DATA_W-1:0] sync1, sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_words;
            sync2 <= sync1;
        end
    end

    assign capSrc = sync2;
`else
    assign capSrc = in_words;
`endif

    assign req_ready  = !respValid || resp_ready;
    assign accept     = req_valid && req_ready;
    assign resp_valid = respValid;
    assign resp_rdata = respRdata;
    assign resp_err   = respErr;

    assign idx     = req_addr[5:2];
    assign aligned = req_addr[1:0] == 2'b00;
    assign inRange = req_addr[ADDR_W-1:8] == '0;
    assign isIn    = req_addr[7:6] == 2'b00;
    assign isOut   = req_addr[7:6] == 2'b01;
    assign isStat  = req_addr[7:2] == 6'b100000;

    always_comb begin
        inHit    = 1'b0;
        outHit   = 1'b0;
        inData   = '0;
        outData  = '0;
        statWord = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            changeNow[i] = inCap[i] != inPrev[i];
            if (idx == 4'(i)) begin
                inHit  = 1'b1;
                inData = inCap[i];
            end
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (idx == 4'(j)) begin
                outHit  = 1'b1;
                outData = outReg[j];
            end
        end
        statWord[NUM_IN-1:0] = flags;
    end

    // IN and STATUS are read-only; any other miss is an error with no side effect
    always_comb begin
        okAcc = aligned && inRange &&
                ((isIn && inHit && !req_we) ||
                 (isOut && outHit) ||
                 (isStat && !req_we));
        rdVal = '0;
        if (okAcc && !req_we) begin
            unique case (1'b1)
                isIn:    rdVal = inData;
                isOut:   rdVal = outData;
                isStat:  rdVal = statWord;
                default: rdVal = '0;
            endcase
        end
    end

    assign statRead = accept && okAcc && isStat;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                inCap[i]  <= '0;
                inPrev[i] <= '0;
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                outReg[j] <= OUT_RESET;
            end
            flags     <= '0;
            respValid <= 1'b0;
            respRdata <= '0;
            respErr   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                inCap[i]  <= capSrc[i*DATA_W +: DATA_W];
                inPrev[i] <= inCap[i];
            end
            // A change seen in the clearing cycle must survive the clear
            flags <= (statRead ? '0 : flags) | changeNow;
            if (accept && req_we && okAcc && isOut) begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    if (idx == 4'(j)) begin
                        for (int b = 0; b < BE_W; b++) begin
                            if (req_be[b]) begin
                                outReg[j][8*b +: 8] <= req_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
            if (accept) begin
                respValid <= 1'b1;
                respRdata <= rdVal;
                respErr   <= !okAcc;
            end else if (resp_ready) begin
                respValid <= 1'b0;
            end
        end
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        assign out_words[j*DATA_W +: DATA_W] = outReg[j];
    end

endmodule

// File: tb/tb_mmio_word_ports.sv
// Directed bench for mmio_word_ports with a cycle-level reference model.
// Build with +define+INPUT_SYNC_EN to exercise the synchronised inputs.
module tb_mmio_word_ports;
    localparam int NI = 2;
    localparam int NO = 2;
`ifdef INPUT_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic          clock = 0;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [31:0]   req_addr, req_wdata;
    logic [3:0]    req_be;
    logic          resp_valid, resp_ready, resp_err;
    logic [31:0]   resp_rdata;
    logic [NI*32-1:0] in_words;
    logic [NO*32-1:0] out_words;

    int nCmp = 0;
    int nBad = 0;
    logic checking = 0;

    mmio_word_ports #(
        .DATA_W(32), .ADDR_W(32), .NUM_IN(NI), .NUM_OUT(NO), .OUT_RESET(32'h0)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .in_words(in_words), .out_words(out_words)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: registers as the programmer sees them
    logic [31:0]   mOut [NO];
    logic [31:0]   mCap [NI];
    logic [31:0]   hist [3][NI];
    logic [NI-1:0] mFlags, mChg;
    logic          mRv, mErr;
    logic [31:0]   mRd;

    always @(posedge clock) begin : model
        logic          acc, err, clr;
        logic [31:0]   rd, a;
        int            idx;
        logic [31:0]   nOut [NO];
        logic [31:0]   nHist [3][NI];
        logic [NI-1:0] chg;
        if (reset) begin
            for (int j = 0; j < NO; j++) mOut[j] <= 32'h0;
            for (int i = 0; i < NI; i++) begin
                mCap[i] <= 32'h0;
                for (int k = 0; k < 3; k++) hist[k][i] <= 32'h0;
            end
            mFlags <= '0;
            mChg   <= '0;
            mRv    <= 1'b0;
            mRd    <= 32'h0;
            mErr   <= 1'b0;
        end else begin
            acc  = req_valid && (!mRv || resp_ready);
            err  = 1'b1;
            rd   = 32'h0;
            clr  = 1'b0;
            a    = req_addr;
            idx  = int'(a[5:2]);
            nOut = mOut;
            if (a[1:0] == 2'b00) begin
                if (a < 32'h40) begin
                    if (!req_we && idx < NI) begin
                        err = 1'b0;
                        rd  = mCap[idx];
                    end
                end else if (a < 32'h80) begin
                    if (idx < NO) begin
                        err = 1'b0;
                        if (req_we) begin
                            for (int b = 0; b < 4; b++)
                                if (req_be[b]) nOut[idx][8*b +: 8] = req_wdata[8*b +: 8];
                        end else begin
                            rd = mOut[idx];
                        end
                    end
                end else if (a == 32'h80 && !req_we) begin
                    err = 1'b0;
                    rd  = 32'(mFlags);
                    clr = 1'b1;
                end
            end
            if (acc) mOut <= nOut;
            mFlags <= ((acc && clr) ? '0 : mFlags) | mChg;
            for (int i = 0; i < NI; i++) begin
                nHist[2][i] = hist[1][i];
                nHist[1][i] = hist[0][i];
                nHist[0][i] = in_words[i*32 +: 32];
                chg[i] = nHist[D][i] != mCap[i];
                mCap[i] <= nHist[D][i];
            end
            hist <= nHist;
            mChg <= chg;
            if (acc) begin
                mRv  <= 1'b1;
                mRd  <= rd;
                mErr <= err;
            end else if (resp_ready) begin
                mRv <= 1'b0;
            end
        end
    end

    always begin : compare
        logic [NO*32-1:0] expOut;
        @(negedge clock);
        #2;
        if (checking) begin
            for (int j = 0; j < NO; j++) expOut[j*32 +: 32] = mOut[j];
            chk("cyc.req_ready", 64'(req_ready), 64'(!mRv || resp_ready));
            chk("cyc.resp_valid", 64'(resp_valid), 64'(mRv));
            chk("cyc.resp_rdata", 64'(resp_rdata), 64'(mRd));
            chk("cyc.resp_err", 64'(resp_err), 64'(mErr));
            chk("cyc.out_words", 64'(out_words), 64'(expOut));
        end
    end

    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] expRd, input logic expErr,
                          input string nm);
        int n = 0;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!req_ready) begin
            nCmp++;
            nBad++;
            $display("FAIL %s: accept timeout ready=%b", nm, req_ready);
        end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        chk({nm, ".valid"}, 64'(resp_valid), 64'h1);
        chk({nm, ".rdata"}, 64'(resp_rdata), 64'(expRd));
        chk({nm, ".err"}, 64'(resp_err), 64'(expErr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_be     = 4'h0;
        resp_ready = 1'b1;
        in_words   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        checking = 1'b1;
        #1;
        chk("rst.out_words", 64'(out_words), 64'h0);
        chk("rst.resp_valid", 64'(resp_valid), 64'h0);
        access(0, 32'h80, 0, 0, 32'h0, 0, "rst.status");

        access(1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 0, "st.full");
        access(1, 32'h40, 32'h000000AA, 4'h1, 32'h0, 0, "st.byte0");
        chk("st.out0", 64'(out_words[31:0]), 64'hDEADBEAA);
        access(0, 32'h40, 0, 0, 32'hDEADBEAA, 0, "ld.out0");
        access(1, 32'h44, 32'h12345678, 4'hC, 32'h0, 0, "st.upper");
        access(1, 32'h44, 32'hFFFFFFFF, 4'h0, 32'h0, 0, "st.be0");
        access(0, 32'h44, 0, 0, 32'h12340000, 0, "ld.out1");

        @(negedge clock);
        in_words = {32'h00001234, 32'h0};
`ifdef INPUT_SYNC_EN
        repeat (2) @(posedge clock);
`endif
        repeat (2) @(posedge clock);
        access(0, 32'h80, 0, 0, 32'h2, 0, "flag.status");
        access(0, 32'h04, 0, 0, 32'h1234, 0, "flag.in1");
        access(0, 32'h80, 0, 0, 32'h0, 0, "flag.cleared");

        access(0, 32'h42, 0, 0, 32'h0, 1, "err.misalign");
        access(0, 32'h48, 0, 0, 32'h0, 1, "err.out2");
        access(0, 32'h08, 0, 0, 32'h0, 1, "err.in2");
        access(0, 32'h100, 0, 0, 32'h0, 1, "err.high");
        access(1, 32'h00, 32'h55555555, 4'hF, 32'h0, 1, "err.st_in");
        access(1, 32'h80, 32'h55555555, 4'hF, 32'h0, 1, "err.st_stat");
        chk("err.out_words", 64'(out_words), 64'h12340000_DEADBEAA);

        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h11223344;
        req_be    = 4'hF;
        @(negedge clock);
        req_we = 1'b0;
        #1;
        chk("b2b.st_err", 64'(resp_err), 64'h0);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        chk("b2b.ld_rdata", 64'(resp_rdata), 64'h11223344);

        @(negedge clock);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h44;
        @(negedge clock);
        req_addr = 32'h04;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            chk("bp.ready", 64'(req_ready), 64'h0);
            chk("bp.heldA", 64'(resp_rdata), 64'h12340000);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        #1;
        chk("bp.release", 64'(req_ready), 64'h1);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        chk("bp.B.valid", 64'(resp_valid), 64'h1);
        chk("bp.B.rdata", 64'(resp_rdata), 64'h1234);

        @(negedge clock);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h44;
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        chk("rst2.pending", 64'(resp_valid), 64'h1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("rst2.resp_valid", 64'(resp_valid), 64'h0);
        chk("rst2.out_words", 64'(out_words), 64'h0);
        reset      = 1'b0;
        resp_ready = 1'b1;
        repeat (4) @(posedge clock);
        access(0, 32'h80, 0, 0, 32'h2, 0, "rst2.status");

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
